// File: rtl/uart_rx_status_fifo.sv
// RX character FIFO carrying per-byte {brk,fe,pe} tags, FWFT read side, trigger/error/overflow flags.
// Optional character-timeout interrupt is built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_status_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int TIMEOUT_BITS = 40,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_pe,
  input  logic                  wr_fe,
  input  logic                  wr_brk,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [2:0]            rd_err,
  input  logic                  fifo_clear,
  input  logic                  ovf_clr,
  input  logic [AW-1:0]         trig_level,
  input  logic                  bit_tick,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  trig_irq,
  output logic                  err_in_fifo,
  output logic                  overflow,
  output logic                  timeout_irq
);
  localparam int EW = DATA_WIDTH + 3;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, err_cnt;
  logic [EW-1:0] head;
  logic          pop, push, wr_tagged, head_tagged, drop;
  logic [AW:0]   thr;

  assign head        = mem[rd_ptr];
  assign empty       = (cnt == '0);
  assign full        = (cnt == (AW+1)'(FIFO_DEPTH));
  assign count       = cnt;
  assign err_in_fifo = (err_cnt != '0);

  // Flush dominates both ports; a full FIFO still accepts a write when a pop frees a slot.
  assign pop         = rd_en && !empty && !fifo_clear;
  assign push        = wr_en && (!full || (rd_en && !empty)) && !fifo_clear;
  assign drop        = wr_en && full && !(rd_en && !empty) && !fifo_clear;
  assign wr_tagged   = wr_pe | wr_fe | wr_brk;
  assign head_tagged = |head[EW-1:DATA_WIDTH];

  assign rd_data = empty ? '0 : head[DATA_WIDTH-1:0];
  assign rd_err  = empty ? '0 : head[EW-1:DATA_WIDTH];

  assign thr      = (trig_level == '0) ? (AW+1)'(1) : {1'b0, trig_level};
  assign trig_irq = (cnt >= thr);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_brk, wr_fe, wr_pe, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else if (fifo_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case ({push && wr_tagged, pop && head_tagged})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: err_cnt <= err_cnt;
      endcase
      // A dropped write in the same cycle as ovf_clr keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  logic [TW-1:0] idle_cnt;
  logic          to_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      to_irq   <= 1'b0;
    end else if (fifo_clear || push || pop || empty) begin
      idle_cnt <= '0;
      to_irq   <= 1'b0;
    end else if (bit_tick && (idle_cnt != TW'(TIMEOUT_BITS))) begin
      idle_cnt <= idle_cnt + 1'b1;
      // Fire on the tick that brings the idle count to the limit.
      if (idle_cnt == TW'(TIMEOUT_BITS - 1)) to_irq <= 1'b1;
    end
  end

  assign timeout_irq = to_irq;
`else
  logic unused_timeout;
  assign unused_timeout = bit_tick ^ (TIMEOUT_BITS == 0);
  assign timeout_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_status_fifo.sv
// Scoreboarded random + directed bench for uart_rx_status_fifo against a queue-based model.
module tb_uart_rx_status_fifo;
  localparam int DW = 8, D = 16, AW = 4, TOB = 40;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          wr_en = 0, wr_pe = 0, wr_fe = 0, wr_brk = 0, rd_en = 0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic [2:0]    rd_err;
  logic          fifo_clear = 0, ovf_clr = 0, bit_tick = 0;
  logic [AW-1:0] trig_level = 4'd1;
  logic          empty, full, trig_irq, err_in_fifo, overflow, timeout_irq;
  logic [AW:0]   count;

  uart_rx_status_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_pe(wr_pe), .wr_fe(wr_fe),
    .wr_brk(wr_brk), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err), .fifo_clear(fifo_clear),
    .ovf_clr(ovf_clr), .trig_level(trig_level), .bit_tick(bit_tick), .empty(empty), .full(full),
    .count(count), .trig_irq(trig_irq), .err_in_fifo(err_in_fifo), .overflow(overflow),
    .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] err; logic [DW-1:0] data; } ent_t;
  ent_t mq[$];
  ent_t exp_q[$];
  ent_t mon_e;
  logic movf = 0, mto = 0;
  int   midle = 0;
  int   n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_err();
    foreach (mq[i]) if (mq[i].err != 3'b0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_status(input string tag);
    int sz, thr;
    sz  = mq.size();
    thr = (trig_level == 0) ? 1 : int'(trig_level);
    chk({tag, ".count"}, count, sz);
    chk({tag, ".empty"}, empty, sz == 0);
    chk({tag, ".full"}, full, sz == D);
    chk({tag, ".overflow"}, overflow, movf);
    chk({tag, ".err_in_fifo"}, err_in_fifo, m_err());
    chk({tag, ".trig_irq"}, trig_irq, sz >= thr);
    chk({tag, ".timeout_irq"}, timeout_irq, mto);
    chk({tag, ".rd_data"}, rd_data, sz ? mq[0].data : 0);
    chk({tag, ".rd_err"}, rd_err, sz ? mq[0].err : 0);
  endtask

  // One clock of stimulus; the model advances by the plain queue rules afterwards.
  task automatic step(input bit wr, input logic [DW-1:0] wd, input logic [2:0] tg, input bit rd,
                      input bit clr = 0, input bit oc = 0, input bit tk = 0, input string tag = "step");
    int sz; bit p, w;
    wr_en = wr; wr_data = wd; {wr_brk, wr_fe, wr_pe} = tg; rd_en = rd;
    fifo_clear = clr; ovf_clr = oc; bit_tick = tk;
    if (rd && !clr && mq.size() > 0) exp_q.push_back(mq[0]);
    @(posedge clk); #1;
    sz = mq.size();
    if (clr) begin
      mq.delete(); movf = 0; midle = 0; mto = 0;
    end else begin
      p = rd && sz > 0;
      w = wr && (sz < D || p);
      if (wr && sz == D && !p) movf = 1; else if (oc) movf = 0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
      if (p || w || sz == 0) begin midle = 0; mto = 0; end
      else if (tk && midle < TOB) begin midle++; if (midle == TOB) mto = 1; end
`endif
      if (p) void'(mq.pop_front());
      if (w) mq.push_back({tg, wd});
    end
    wr_en = 0; rd_en = 0; fifo_clear = 0; ovf_clr = 0; bit_tick = 0;
    {wr_brk, wr_fe, wr_pe} = 3'b0;
    check_status(tag);
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_en && !empty && !fifo_clear) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("pop_data", rd_data, mon_e.data);
        chk("pop_err", rd_err, mon_e.err);
      end
    end
  end

  task automatic drain();
    while (mq.size() > 0) step(0, 0, 0, 1, 0, 0, 0, "drain");
  endtask

  initial begin
    #12;
    check_status("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // T1: FWFT order
    step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0, 0, 0, 0, "t1_fill");
    chk("t1_count", count, 3); chk("t1_head", rd_data, 8'h11);
    repeat (3) step(0, 0, 0, 1, 0, 0, 0, "t1_pop");
    chk("t1_empty", empty, 1); chk("t1_rd0", rd_data, 0);

    // T2: overflow and full-with-simultaneous-pop
    for (int i = 0; i < D; i++) step(1, 8'(i * 7 + 1), 0, 0, 0, 0, 0, "t2_fill");
    step(1, 8'hAA, 0, 0, 0, 0, 0, "t2_ovf");
    chk("t2_full", full, 1); chk("t2_overflow", overflow, 1);
    step(1, 8'hBB, 0, 1, 0, 0, 0, "t2_wrrd");
    chk("t2_cnt16", count, 16); chk("t2_ovf_hold", overflow, 1);
    step(1, 8'hCC, 0, 0, 0, 1, 0, "t2_set_vs_clr");
    chk("t2_set_wins", overflow, 1);
    drain();
    step(0, 0, 0, 0, 0, 1, 0, "t2_ovfclr");
    chk("t2_ovf_cleared", overflow, 0);

    // T3: error tag follows its byte
    step(1, 8'h01, 0, 0); step(1, 8'h55, 3'b010, 0); step(1, 8'h02, 0, 0, 0, 0, 0, "t3_fill");
    chk("t3_err_in", err_in_fifo, 1);
    step(0, 0, 0, 1, 0, 0, 0, "t3_pop1");
    chk("t3_rd_err", rd_err, 3'b010);
    step(0, 0, 0, 1, 0, 0, 0, "t3_pop2");
    chk("t3_err_gone", err_in_fifo, 0);
    drain();

    // T4: trigger level
    trig_level = 4;
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 0, 0, 0, 0, "t4_fill");
    chk("t4_below", trig_irq, 0);
    step(1, 8'h43, 0, 0, 0, 0, 0, "t4_at");
    chk("t4_at4", trig_irq, 1);
    step(0, 0, 0, 1, 0, 0, 0, "t4_pop");
    chk("t4_at3", trig_irq, 0);
    drain();
    trig_level = 0;
    step(1, 8'h77, 0, 0, 0, 0, 0, "t4_zero");
    chk("t4_lvl0", trig_irq, 1);
    drain();

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // T5: character timeout
    step(1, 8'h5A, 0, 0);
    repeat (TOB - 1) step(0, 0, 0, 0, 0, 0, 1, "t5_idle");
    chk("t5_before", timeout_irq, 0);
    step(0, 0, 0, 0, 0, 0, 1, "t5_tick40");
    chk("t5_fire", timeout_irq, 1);
    step(0, 0, 0, 1, 0, 0, 0, "t5_pop");
    chk("t5_popclr", timeout_irq, 0);
    step(1, 8'h5B, 0, 0);
    repeat (TOB - 1) step(0, 0, 0, 0, 0, 0, 1, "t5_idle2");
    step(1, 8'h5C, 0, 0, 0, 0, 1, "t5_wr");
    repeat (5) step(0, 0, 0, 0, 0, 0, 1, "t5_after");
    chk("t5_noirq", timeout_irq, 0);
    drain();
`endif

    // T6: flush overrides everything
    trig_level = 1;
    for (int i = 0; i < D; i++) step(1, 8'(i), (i == 12) ? 3'b001 : 3'b000, 0, 0, 0, 0, "t6_fill");
    step(1, 8'hEE, 0, 0, 0, 0, 0, "t6_ovf");
    repeat (9) step(0, 0, 0, 1, 0, 0, 0, "t6_pop");
    chk("t6_pre_cnt", count, 7); chk("t6_pre_err", err_in_fifo, 1);
    step(1, 8'h99, 3'b100, 1, 1, 0, 0, "t6_clear");
    chk("t6_cnt", count, 0); chk("t6_empty", empty, 1);
    chk("t6_ovf", overflow, 0); chk("t6_err", err_in_fifo, 0);

    // Async reset mid-burst
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 3'(i), 0, 0, 0, 1, "rst_fill");
    #2 rst_n = 0;
    #1;
    mq.delete(); exp_q.delete(); movf = 0; midle = 0; mto = 0;
    check_status("async_rst");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Random phase: alternating fill-biased and drain-biased segments
    for (int s = 0; s < 16; s++) begin
      int wp, rp;
      trig_level = 4'($urandom_range(0, 15));
      wp = (s % 2) ? 30 : 85;
      rp = (s % 2) ? 80 : 25;
      for (int c = 0; c < 150; c++) begin
        step($urandom_range(0, 99) < wp, 8'($urandom),
             ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
             $urandom_range(0, 99) < rp, $urandom_range(0, 199) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 8, "rand");
      end
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
